// File: rtl/channel_arb_pkg.sv
// Shared definitions for the channel write arbiter slice.
//   arb_state_e : arbiter FSM state encoding (GRANT=0, WAIT=1, PUSH=2)
//   clog2_min1  : pointer/counter width helper, ceil(log2(n)) but never below 1
package channel_arb_pkg;

  typedef enum logic [1:0] {
    ST_GRANT = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PUSH  = 2'd2
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/rr_window_pointer.sv
// Round-robin grant pointer with a per-grant time window.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   advance_now  : move to the next requester immediately and restart the window
//   tick         : one cycle of the window has elapsed while granting
//   grant_id     : current grant pointer, wraps NREQ-1 -> 0
module rr_window_pointer
  import channel_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WINDOW = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          advance_now,
  input  logic                          tick,
  output logic [clog2_min1(NREQ)-1:0]   grant_id
);

  localparam int PTR_W = clog2_min1(NREQ);
  localparam int CW    = clog2_min1(WINDOW);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREQ - 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WINDOW - 1);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic [CW-1:0]    r_cnt;

  // Next pointer with explicit wrap so non-power-of-2 NREQ never reaches NREQ.
  always_comb begin
    if (r_ptr == LAST_PTR) begin
      w_ptr_next = {PTR_W{1'b0}};
    end else begin
      w_ptr_next = r_ptr + PTR_W'(1);
    end
  end

  // Pointer and window counter; an accept restarts the window on the next requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {PTR_W{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (advance_now) begin
      r_ptr <= w_ptr_next;
      r_cnt <= {CW{1'b0}};
    end else if (tick) begin
      if (r_cnt == LAST_CNT) begin
        r_ptr <= w_ptr_next;
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_ptr <= r_ptr;
      r_cnt <= r_cnt;
    end
  end

  assign grant_id = r_ptr;

endmodule

// File: rtl/channel_write_arbiter.sv
// Time-slice arbiter sharing one channel write port among NREQ kernels.
// A granted requester's word is captured into a one-entry buffer, then
// replayed to the shared channel: wait for ch_write_ready, pulse ch_write_valid.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   req_in_data             : requester i data at [i*WIDTH +: WIDTH]
//   req_write_valid         : per-requester one-cycle write pulse
//   req_write_ready         : one-hot grant, only while in GRANT
//   ch_in_data              : buffered word to the channel (held in every state)
//   ch_write_valid          : one-cycle write pulse to the channel
//   ch_write_ready          : channel can accept a write
//   grant_id                : current grant pointer
//   busy                    : buffer holds data (WAIT or PUSH)
//   xfer_count              : words pushed to the channel, wraps
//   drop_err                : sticky, a non-granted requester pulsed valid
module channel_write_arbiter
  import channel_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int WINDOW = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ*WIDTH-1:0]        req_in_data,
  input  logic [NREQ-1:0]              req_write_valid,
  output logic [NREQ-1:0]              req_write_ready,
  output logic [WIDTH-1:0]             ch_in_data,
  output logic                         ch_write_valid,
  input  logic                         ch_write_ready,
  output logic [clog2_min1(NREQ)-1:0]  grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             xfer_count,
  output logic                         drop_err
);

  localparam int PTR_W = clog2_min1(NREQ);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [PTR_W-1:0]  w_grant_id;
  logic              w_sel_valid;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_accept;
  logic              w_tick;
  logic [NREQ-1:0]   w_ready;
  logic              w_ch_valid;
  logic              w_busy;
  logic [WIDTH-1:0]  r_buffer;
  logic [CNT_W-1:0]  r_xfer_count;
  logic              r_drop_err;

  rr_window_pointer #(
    .NREQ   (NREQ),
    .WINDOW (WINDOW)
  ) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .advance_now (w_accept),
    .tick        (w_tick),
    .grant_id    (w_grant_id)
  );

  // Select the granted requester's valid and data.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_sel_valid = (w_grant_id == PTR_W'(i)) ? req_write_valid[i] : w_sel_valid;
      w_sel_data  = (w_grant_id == PTR_W'(i)) ? req_in_data[i*WIDTH +: WIDTH] : w_sel_data;
    end
  end

  // Accept beats rotation; the window only runs while granting.
  always_comb begin
    w_tick   = (r_state == ST_GRANT);
    w_accept = (r_state == ST_GRANT) && w_sel_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_GRANT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_GRANT: begin
        if (w_sel_valid) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_GRANT;
        end
      end
      ST_WAIT: begin
        if (ch_write_ready) begin
          w_next_state = ST_PUSH;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_PUSH: w_next_state = ST_GRANT;
      default: w_next_state = ST_GRANT;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    w_ready    = {NREQ{1'b0}};
    w_ch_valid = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_GRANT: begin
        for (int i = 0; i < NREQ; i++) begin
          w_ready[i] = (w_grant_id == PTR_W'(i));
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
      end
      ST_PUSH: begin
        w_busy     = 1'b1;
        w_ch_valid = 1'b1;
      end
      default: begin
        w_busy     = 1'b0;
        w_ch_valid = 1'b0;
      end
    endcase
  end

  // Capture buffer; reset discards any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buffer <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_buffer <= w_sel_data;
    end else begin
      r_buffer <= r_buffer;
    end
  end

  // Transfer counter, one per PUSH cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= {CNT_W{1'b0}};
    end else if (r_state == ST_PUSH) begin
      r_xfer_count <= r_xfer_count + CNT_W'(1);
    end else begin
      r_xfer_count <= r_xfer_count;
    end
  end

  // Sticky error: any valid on a requester whose ready is low (covers WAIT/PUSH).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= r_drop_err | (|(req_write_valid & ~w_ready));
    end
  end

  assign req_write_ready = w_ready;
  assign ch_in_data      = r_buffer;
  assign ch_write_valid  = w_ch_valid;
  assign grant_id        = w_grant_id;
  assign busy            = w_busy;
  assign xfer_count      = r_xfer_count;
  assign drop_err        = r_drop_err;

endmodule
